// File: rtl/rv_decoder_if.sv
// ============================================================================
//  Module      : rv_decoder_if
//  Description : Decode-stage bus. It carries the instruction, the enable, the
//                register snapshot, and the registered operands/destination.
//                Adds `illegal` when RV_DECODER_ILLEGAL_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv_decoder_if;
  logic [31:0] instr;
  logic        enable;
  logic [31:0] register_bank [32];
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] op3;
  logic [4:0]  rd;
`ifdef RV_DECODER_ILLEGAL_EN
  logic        illegal;
`endif

  modport master (
    output instr, enable, register_bank,
`ifdef RV_DECODER_ILLEGAL_EN
    input  illegal,
`endif
    input  op1, op2, op3, rd
  );

  modport slave (
    input  instr, enable, register_bank,
`ifdef RV_DECODER_ILLEGAL_EN
    output illegal,
`endif
    output op1, op2, op3, rd
  );
endinterface

`default_nettype wire

// File: rtl/rv_decoder.sv
// ============================================================================
//  Module      : rv_decoder
//  Description : RV32I decode/operand-fetch stage. It produces registered
//                op1/op2/op3/rd. The optional output `illegal` is added when
//                RV_DECODER_ILLEGAL_EN is defined. A nonzero random_errors
//                builds a faulty variant that flips op2 bit 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_decoder #(
  parameter int random_errors = 0
) (
  input  wire          clk,
  input  wire          rst,
  rv_decoder_if.slave  bus
);

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_system = 7'b1110011;
  localparam logic [6:0] c_opc_misc   = 7'b0001111;
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd_idx;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_op3;
  logic [4:0]  w_rd;
  logic        w_illegal;
  logic        w_flip;

  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [31:0] r_op3;
  logic [4:0]  r_rd;

  assign w_opcode  = bus.instr[6:0];
  assign w_rd_idx  = bus.instr[11:7];
  assign w_rs1     = bus.instr[19:15];
  assign w_rs2     = bus.instr[24:20];

  // x0 reads as zero regardless of what the snapshot holds
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : bus.register_bank[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : bus.register_bank[w_rs2];

  assign w_imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign w_imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign w_imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                    bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign w_imm_u = {bus.instr[31:12], 12'd0};
  assign w_imm_j = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                    bus.instr[20], bus.instr[30:21], 1'b0};

  always_comb begin
    w_op1     = 32'd0;
    w_op2     = 32'd0;
    w_op3     = 32'd0;
    w_rd      = 5'd0;
    w_illegal = 1'b0;
    case (w_opcode)
      c_opc_op: begin
        w_op1 = w_rs1_val;
        w_op2 = w_rs2_val;
        w_rd  = w_rd_idx;
      end
      c_opc_op_imm, c_opc_load, c_opc_jalr: begin
        w_op1 = w_rs1_val;
        w_op2 = w_imm_i;
        w_rd  = w_rd_idx;
      end
      c_opc_store: begin
        w_op1 = w_rs1_val;
        w_op2 = w_imm_s;
        w_op3 = w_rs2_val;
      end
      c_opc_branch: begin
        w_op1 = w_rs1_val;
        w_op2 = w_rs2_val;
        w_op3 = w_imm_b;
      end
      c_opc_lui, c_opc_auipc: begin
        w_op2 = w_imm_u;
        w_rd  = w_rd_idx;
      end
      c_opc_jal: begin
        w_op2 = w_imm_j;
        w_rd  = w_rd_idx;
      end
      c_opc_system, c_opc_misc: ;
      default: w_illegal = 1'b1;
    endcase
  end

  generate
    if (random_errors != 0) begin : g_lfsr
      logic [15:0] r_lfsr;
      logic [15:0] w_lfsr_next;

      // Right-shifting Fibonacci form of taps 16,14,13,11
      assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5],
                            r_lfsr[15:1]};
      assign w_flip      = (w_lfsr_next[3:0] == 4'h0);

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_lfsr <= c_lfsr_seed;
        end else if (bus.enable) begin
          r_lfsr <= w_lfsr_next;
        end
      end
    end else begin : g_no_lfsr
      assign w_flip = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op1 <= 32'd0;
      r_op2 <= 32'd0;
      r_op3 <= 32'd0;
      r_rd  <= 5'd0;
    end else if (bus.enable) begin
      r_op1 <= w_op1;
      r_op2 <= w_op2 ^ {31'd0, w_flip};
      r_op3 <= w_op3;
      r_rd  <= w_rd;
    end
  end

  assign bus.op1 = r_op1;
  assign bus.op2 = r_op2;
  assign bus.op3 = r_op3;
  assign bus.rd  = r_rd;

`ifdef RV_DECODER_ILLEGAL_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_illegal <= 1'b0;
    end else if (bus.enable) begin
      r_illegal <= w_illegal;
    end
  end

  assign bus.illegal = r_illegal;
`else
  logic w_unused;
  assign w_unused = w_illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_decoder.sv
// ============================================================================
//  Module      : tb_rv_decoder
//  Description : Scoreboard bench for rv_decoder. It drives a clean instance and
//                a random_errors instance with identical stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_decoder;

  logic clk;
  logic rst;

  rv_decoder_if bus ();
  rv_decoder_if bus_err ();

  rv_decoder #(.random_errors(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  rv_decoder #(.random_errors(1)) dut_err (
    .clk (clk),
    .rst (rst),
    .bus (bus_err.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op3;
    logic [4:0]  rd;
    logic        ill;
    logic        flip;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [15:0] m_lfsr;
  logic [31:0] regs [32];
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rv(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : regs[idx];
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return (l >> 1) | {fb, 15'd0};
  endfunction

  function automatic exp_t decode(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] sx;
    e  = '{op1: 32'd0, op2: 32'd0, op3: 32'd0, rd: 5'd0, ill: 1'b0, flip: 1'b0};
    sx = $unsigned($signed(ins) >>> 20);
    case (ins[6:0])
      7'h33: begin e.op1 = rv(ins[19:15]); e.op2 = rv(ins[24:20]); e.rd = ins[11:7]; end
      7'h13, 7'h03, 7'h67: begin e.op1 = rv(ins[19:15]); e.op2 = sx; e.rd = ins[11:7]; end
      7'h23: begin
        e.op1 = rv(ins[19:15]);
        e.op2 = (sx & ~32'h1F) | {27'd0, ins[11:7]};
        e.op3 = rv(ins[24:20]);
      end
      7'h63: begin
        e.op1 = rv(ins[19:15]);
        e.op2 = rv(ins[24:20]);
        e.op3 = (sx & ~32'hFFF) | {20'd0, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h37, 7'h17: begin e.op2 = ins & 32'hFFFFF000; e.rd = ins[11:7]; end
      7'h6F: begin
        e.op2 = ($unsigned($signed(ins) >>> 11) & 32'hFFF00000)
              | {12'd0, ins[19:12], ins[20], ins[30:21], 1'b0};
        e.rd  = ins[11:7];
      end
      7'h73, 7'h0F: ;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one cycle, push the model's prediction, then compare after the edge
  task automatic cycle(input logic r, input logic en, input logic [31:0] ins);
    exp_t e;
    rst            = r;
    bus.enable     = en;
    bus.instr      = ins;
    bus.register_bank = regs;
    bus_err.enable = en;
    bus_err.instr  = ins;
    bus_err.register_bank = regs;
    if (!r) begin
      cur    = '{op1: 32'd0, op2: 32'd0, op3: 32'd0, rd: 5'd0, ill: 1'b0, flip: 1'b0};
      m_lfsr = 16'hACE1;
    end else if (en) begin
      cur      = decode(ins);
      m_lfsr   = lfsr_step(m_lfsr);
      cur.flip = (m_lfsr[3:0] == 4'h0);
    end
    sb.push_back(cur);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("op1", bus.op1, e.op1);
    check("op2", bus.op2, e.op2);
    check("op3", bus.op3, e.op3);
    check("rd", {27'd0, bus.rd}, {27'd0, e.rd});
`ifdef RV_DECODER_ILLEGAL_EN
    check("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
`endif
    check("op2_faulty", bus_err.op2, e.op2 ^ {31'd0, e.flip});
  endtask

  localparam logic [6:0] c_opcodes [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                            7'h37, 7'h17, 7'h6F, 7'h73, 7'h0F, 7'h7F};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_lfsr   = 16'hACE1;
    cur      = '{op1: 32'd0, op2: 32'd0, op3: 32'd0, rd: 5'd0, ill: 1'b0, flip: 1'b0};
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[1] = 32'd5;
    regs[2] = 32'd7;

    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, $urandom);

    cycle(1'b1, 1'b1, 32'h002081B3);            // ADD x3,x1,x2
    regs[0] = 32'hDEAD;
    cycle(1'b1, 1'b1, 32'h002001B3);            // ADD x3,x0,x2
    cycle(1'b1, 1'b1, 32'hFFF00293);            // ADDI x5,x0,-1
    cycle(1'b1, 1'b1, 32'h123453B7);            // LUI x7,0x12345
    regs[1] = 32'h100;
    regs[2] = 32'hCAFE;
    cycle(1'b1, 1'b1, 32'h0020A423);            // SW x2,8(x1)
    cycle(1'b1, 1'b1, 32'hFE208EE3);            // BEQ x1,x2,-4

    cycle(1'b1, 1'b1, 32'h002081B3);
    for (int i = 0; i < 3; i++) begin
      regs[1] = $urandom;
      regs[2] = $urandom;
      cycle(1'b1, 1'b0, $urandom);
    end
    cycle(1'b1, 1'b1, 32'h00100073);            // EBREAK

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ins;
      for (int k = 1; k < 32; k++) regs[k] = $urandom;
      ins      = $urandom;
      ins[6:0] = c_opcodes[$urandom_range(0, 11)];
      cycle(1'b1, 1'b1, ins);
    end

    cycle(1'b1, 1'b1, 32'h002081B3);
    cycle(1'b0, 1'b1, 32'h002081B3);            // mid-stream reset
    cycle(1'b1, 1'b1, 32'h002081B3);

    for (int i = 0; i < 64; i++) begin
      regs[1] = $urandom;
      regs[2] = $urandom;
      cycle(1'b1, 1'b1, 32'h002081B3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
